// File: rtl/counter_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_timer_ctrl
// Description : Programmable timer controller driving a WIDTH-bit up-counter.
//               It supports START with a limit, STOP/RESUME and CLEAR, and
//               either one-shot or periodic expiry. Each terminal-count event
//               produces a single-cycle expiry pulse and bumps a saturating
//               event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_timer_ctrl #(
    parameter int WIDTH     = 4,
    parameter int EXP_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_cmd_valid,
    output logic                 io_cmd_ready,
    input  logic [1:0]           io_cmd_op,
    input  logic [WIDTH-1:0]     io_cmd_limit,
    input  logic                 io_cmd_periodic,
    output logic [WIDTH-1:0]     io_count,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_expire,
    output logic [EXP_CNT_W-1:0] io_exp_cnt
);

    localparam logic [1:0] c_OP_START  = 2'd0;
    localparam logic [1:0] c_OP_STOP   = 2'd1;
    localparam logic [1:0] c_OP_RESUME = 2'd2;
    localparam logic [1:0] c_OP_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [WIDTH-1:0]       r_count;
    logic [WIDTH-1:0]       w_count_n;
    logic [WIDTH-1:0]       r_limit;
    logic [WIDTH-1:0]       w_limit_n;
    logic                   r_periodic;
    logic                   w_periodic_n;
    logic                   r_expire;
    logic                   w_expire_n;
    logic [EXP_CNT_W-1:0]   r_exp_cnt;
    logic [EXP_CNT_W-1:0]   w_exp_cnt_n;
    logic                   w_fire;

    // Ready drops only while reset is held; every state accepts commands.
    assign io_cmd_ready = ~reset;
    assign w_fire       = io_cmd_valid & io_cmd_ready;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= '0;
            r_periodic <= 1'b0;
            r_expire   <= 1'b0;
            r_exp_cnt  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_count    <= w_count_n;
            r_limit    <= w_limit_n;
            r_periodic <= w_periodic_n;
            r_expire   <= w_expire_n;
            r_exp_cnt  <= w_exp_cnt_n;
        end
    end

    // Next-state logic: an accepted command always wins over counting, so a
    // terminal count coinciding with any fire is deferred or discarded.
    always_comb begin
        w_state_n    = r_state;
        w_count_n    = r_count;
        w_limit_n    = r_limit;
        w_periodic_n = r_periodic;
        w_expire_n   = 1'b0;
        w_exp_cnt_n  = r_exp_cnt;

        if (w_fire) begin
            case (io_cmd_op)
                c_OP_START: begin
                    w_state_n    = ST_RUN;
                    w_count_n    = '0;
                    w_limit_n    = io_cmd_limit;
                    w_periodic_n = io_cmd_periodic;
                    w_exp_cnt_n  = '0;
                end
                c_OP_STOP: begin
                    if (r_state == ST_RUN) begin
                        w_state_n = ST_PAUSE;
                    end
                end
                c_OP_RESUME: begin
                    if (r_state == ST_PAUSE) begin
                        w_state_n = ST_RUN;
                    end
                end
                c_OP_CLEAR: begin
                    w_state_n   = ST_IDLE;
                    w_count_n   = '0;
                    w_exp_cnt_n = '0;
                end
                default: begin
                    w_state_n = r_state;
                end
            endcase
        end else if (r_state == ST_RUN) begin
            if (r_count != r_limit) begin
                w_count_n = r_count + WIDTH'(1);
            end else begin
                w_expire_n = 1'b1;
                if (r_exp_cnt != {EXP_CNT_W{1'b1}}) begin
                    w_exp_cnt_n = r_exp_cnt + EXP_CNT_W'(1);
                end
                if (r_periodic) begin
                    w_count_n = '0;
                end else begin
                    w_state_n = ST_DONE;
                end
            end
        end
    end

    assign io_count   = r_count;
    assign io_busy    = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign io_done    = (r_state == ST_DONE);
    assign io_expire  = r_expire;
    assign io_exp_cnt = r_exp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_counter_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_timer_ctrl
// Description : Self-checking bench for counter_timer_ctrl. Two instances
//               (default expiry counter width and a 2-bit one) share one
//               stimulus stream and are compared every cycle with a
//               behavioural model; a few literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_timer_ctrl;

    localparam int WIDTH = 4;
    localparam int ECW_A = 8;
    localparam int ECW_B = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_limit = '0;
    logic             cmd_periodic = 1'b0;

    logic             a_ready, a_busy, a_done, a_expire;
    logic [WIDTH-1:0] a_count;
    logic [ECW_A-1:0] a_exp_cnt;
    logic             b_ready, b_busy, b_done, b_expire;
    logic [WIDTH-1:0] b_count;
    logic [ECW_B-1:0] b_exp_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // Behavioural model: mode, count, limit, and an unbounded expiry total.
    int m_mode    = M_IDLE;
    int m_count   = 0;
    int m_limit   = 0;
    bit m_per     = 1'b0;
    bit m_expire  = 1'b0;
    int m_total   = 0;

    counter_timer_ctrl #(.WIDTH(WIDTH), .EXP_CNT_W(ECW_A)) dut_a (
        .clock(clock), .reset(reset),
        .io_cmd_valid(cmd_valid), .io_cmd_ready(a_ready),
        .io_cmd_op(cmd_op), .io_cmd_limit(cmd_limit),
        .io_cmd_periodic(cmd_periodic),
        .io_count(a_count), .io_busy(a_busy), .io_done(a_done),
        .io_expire(a_expire), .io_exp_cnt(a_exp_cnt)
    );

    counter_timer_ctrl #(.WIDTH(WIDTH), .EXP_CNT_W(ECW_B)) dut_b (
        .clock(clock), .reset(reset),
        .io_cmd_valid(cmd_valid), .io_cmd_ready(b_ready),
        .io_cmd_op(cmd_op), .io_cmd_limit(cmd_limit),
        .io_cmd_periodic(cmd_periodic),
        .io_count(b_count), .io_busy(b_busy), .io_done(b_done),
        .io_expire(b_expire), .io_exp_cnt(b_exp_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model update on each rising edge from the inputs present at that edge.
    always @(posedge clock) begin
        m_expire = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_count = 0; m_limit = 0; m_per = 1'b0; m_total = 0;
        end else if (cmd_valid) begin
            case (cmd_op)
                2'd0: begin
                    m_mode = M_RUN; m_count = 0; m_limit = int'(cmd_limit);
                    m_per = cmd_periodic; m_total = 0;
                end
                2'd1: if (m_mode == M_RUN) m_mode = M_PAUSE;
                2'd2: if (m_mode == M_PAUSE) m_mode = M_RUN;
                default: begin m_mode = M_IDLE; m_count = 0; m_total = 0; end
            endcase
        end else if (m_mode == M_RUN) begin
            if (m_count < m_limit) begin
                m_count = m_count + 1;
            end else begin
                m_expire = 1'b1;
                m_total  = m_total + 1;
                if (m_per) m_count = 0;
                else       m_mode  = M_DONE;
            end
        end
        cmp_en = 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ready_a",  {31'd0, a_ready},  {31'd0, !reset});
            chk("ready_b",  {31'd0, b_ready},  {31'd0, !reset});
            chk("count_a",  32'(a_count),      32'(m_count));
            chk("count_b",  32'(b_count),      32'(m_count));
            chk("busy_a",   {31'd0, a_busy},   {31'd0, (m_mode == M_RUN) || (m_mode == M_PAUSE)});
            chk("busy_b",   {31'd0, b_busy},   {31'd0, (m_mode == M_RUN) || (m_mode == M_PAUSE)});
            chk("done_a",   {31'd0, a_done},   {31'd0, m_mode == M_DONE});
            chk("done_b",   {31'd0, b_done},   {31'd0, m_mode == M_DONE});
            chk("expire_a", {31'd0, a_expire}, {31'd0, m_expire});
            chk("expire_b", {31'd0, b_expire}, {31'd0, m_expire});
            chk("expcnt_a", 32'(a_exp_cnt),    32'(sat(m_total, ECW_A)));
            chk("expcnt_b", 32'(b_exp_cnt),    32'(sat(m_total, ECW_B)));
        end
    end

    // Inputs change 1 time unit after a rising edge; tasks start and end there.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input int lim, input bit per);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_limit    = WIDTH'(lim);
        cmd_periodic = per;
        @(posedge clock);
        #1;
        cmd_valid    = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles with a command present.
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_limit = 4'd7;
        idle(2);
        chk("pin_rst_ready", {31'd0, a_ready}, 32'd0);
        reset = 1'b0; cmd_valid = 1'b0;
        chk("pin_rst_count", 32'(a_count), 32'd0);
        chk("pin_rst_done",  {31'd0, a_done}, 32'd0);

        // One-shot, limit 3.
        cmd(2'd0, 3, 1'b0);
        idle(3);
        chk("pin_os_count3",  32'(a_count), 32'd3);
        chk("pin_os_noexp",   {31'd0, a_expire}, 32'd0);
        idle(1);
        chk("pin_os_expire",  {31'd0, a_expire}, 32'd1);
        chk("pin_os_done",    {31'd0, a_done}, 32'd1);
        idle(1);
        chk("pin_os_expcnt",  32'(a_exp_cnt), 32'd1);
        chk("pin_os_hold",    32'(a_count), 32'd3);

        // Periodic, limit 2, nine cycles -> three expiries.
        cmd(2'd0, 2, 1'b1);
        idle(9);
        chk("pin_per_expcnt", 32'(a_exp_cnt), 32'd3);
        chk("pin_per_count",  32'(a_count), 32'd0);

        // Limit 15 periodic with pause at 5.
        cmd(2'd0, 15, 1'b1);
        idle(5);
        cmd(2'd1, 0, 1'b0);
        idle(4);
        chk("pin_pause_count", 32'(a_count), 32'd5);
        chk("pin_pause_busy",  {31'd0, a_busy}, 32'd1);
        cmd(2'd2, 0, 1'b0);
        idle(1);
        chk("pin_resume_count", 32'(a_count), 32'd6);
        idle(10);
        chk("pin_wrap_expire",  {31'd0, a_expire}, 32'd1);
        chk("pin_wrap_count",   32'(a_count), 32'd0);

        // START on the terminal edge suppresses the expiry.
        cmd(2'd0, 2, 1'b1);
        idle(2);
        cmd(2'd0, 3, 1'b0);
        chk("pin_start_term_exp", {31'd0, a_expire}, 32'd0);
        chk("pin_start_term_cnt", 32'(a_count), 32'd0);

        // CLEAR from DONE.
        idle(4);
        chk("pin_done_before_clr", {31'd0, a_done}, 32'd1);
        cmd(2'd3, 0, 1'b0);
        chk("pin_clr_done",   {31'd0, a_done}, 32'd0);
        chk("pin_clr_expcnt", 32'(a_exp_cnt), 32'd0);

        // Limit 0 periodic: continuous expiry, 2-bit counter saturates.
        cmd(2'd0, 0, 1'b1);
        idle(6);
        chk("pin_l0_expire", {31'd0, b_expire}, 32'd1);
        chk("pin_l0_sat_b",  32'(b_exp_cnt), 32'd3);
        chk("pin_l0_cnt_a",  32'(a_exp_cnt), 32'd6);

        // Reset mid-RUN with a command present.
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_limit = 4'd9;
        idle(1);
        chk("pin_midrst_busy",   {31'd0, a_busy}, 32'd0);
        chk("pin_midrst_expcnt", 32'(a_exp_cnt), 32'd0);
        reset = 1'b0; cmd_valid = 1'b0;

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 99) < 20);
            cmd_op    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) cmd_limit = WIDTH'($urandom_range(0, 2));
            else                           cmd_limit = WIDTH'($urandom_range(0, 15));
            cmd_periodic = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        reset = 1'b0; cmd_valid = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_timer_ctrl.md
Name: counter_timer_ctrl

Overview:
- Programmable timer controller that sequences a WIDTH-bit up-counter datapath: start with a limit, pause/resume, clear, one-shot or periodic expiry.
- Sits between a software/command master and the counter; produces an expiry pulse and status for interrupt logic.
- Commands use a valid/ready handshake; all state is registered on clock.

Parameters:
- WIDTH, 4, counter and limit width in bits
- EXP_CNT_W, 8, width of the saturating expiry-event counter

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- io_cmd_valid  input  1  command present
- io_cmd_ready  output  1  controller accepts command; fire = valid & ready
- io_cmd_op  input  2  0=START, 1=STOP (pause), 2=RESUME, 3=CLEAR
- io_cmd_limit  input  WIDTH  terminal count; sampled on START fire only
- io_cmd_periodic  input  1  1=auto-reload, 0=one-shot; sampled on START fire only
- io_count  output  WIDTH  current counter value
- io_busy  output  1  state is RUN or PAUSE
- io_done  output  1  state is DONE (one-shot finished), level
- io_expire  output  1  registered single-cycle pulse per terminal-count event
- io_exp_cnt  output  EXP_CNT_W  expiries since last START/CLEAR, saturating

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. State IDLE; count=0, limit=0, periodic=0, io_expire=0, io_exp_cnt=0, io_done=0, io_busy=0. io_cmd_ready=0 while reset is high, 1 otherwise.
- io_cmd_ready=1 in every state. Commands illegal in the current state are accepted and ignored (no state change).
- States: IDLE, RUN, PAUSE, DONE.
- START (any state): count<=0, limit<=io_cmd_limit, periodic<=io_cmd_periodic, exp_cnt<=0, state<=RUN.
- STOP: RUN->PAUSE with count held. Ignored in IDLE, PAUSE and DONE.
- RESUME: PAUSE->RUN. Ignored elsewhere.
- CLEAR: any state -> IDLE; count<=0, exp_cnt<=0.
- RUN with no command fire, evaluated each edge:
  - if count!=limit: count<=count+1.
  - if count==limit: io_expire<=1 for the next cycle; exp_cnt<=exp_cnt+1, saturating at 2^EXP_CNT_W-1.
  - on that terminal edge, periodic=1: count<=0 and stay in RUN. periodic=0: count holds at limit and state<=DONE.
- Period: limit+1 cycles.
  - limit=0 and periodic: io_expire high every cycle while in RUN.
  - limit=0 and one-shot: expires one edge after START.
- io_expire is 0 in every cycle not immediately following a terminal edge.
- Priority: a command fire beats terminal-count processing on the same edge.
  - START or STOP at count==limit: no expire, no exp_cnt increment.
  - STOP at terminal, then RESUME: the terminal edge is evaluated at the first RUN edge after RESUME.
- Wrap: count never exceeds limit, so no natural WIDTH overflow occurs. Limit 2^WIDTH-1 counts through all values.
- Reset mid-operation: returns to reset values on the next edge, regardless of any command present.
- Outputs:
  - io_count reflects the register directly.
  - io_busy and io_done are decoded from the state register only, with no combinational path from command inputs.

Test Plan:
- Reset for 2 cycles with io_cmd_valid=1 -> io_cmd_ready=0 during reset. After reset: io_count=0, io_busy=0, io_done=0, io_expire=0, io_exp_cnt=0.
- START limit=3 one-shot -> io_count 0,1,2,3 over 4 cycles. io_expire=1 for exactly 1 cycle, then io_done=1, io_count holds 3, io_exp_cnt=1.
- START limit=2 periodic, run 9 cycles -> io_count 0,1,2,0,1,2,... io_expire pulses every 3 cycles. io_exp_cnt=3.
- START limit=15 periodic, STOP at count=5, idle 4 cycles, RESUME -> count holds 5 while io_busy=1, then resumes 6,7,... and expires after count=15, wrapping to 0.
- Simultaneous events:
  - START issued on the edge where count==limit -> no io_expire, count restarts at 0.
  - CLEAR in DONE -> IDLE, io_done=0, io_exp_cnt=0.
- EXP_CNT_W=2, limit=0 periodic for 6 cycles -> io_expire high continuously, io_exp_cnt saturates at 3. Synchronous reset mid-RUN -> all outputs return to reset values the next cycle.
